// File: rtl/mode_led_driver.sv
// Mode LED driver: shows the assist-mode setting on two LEDs and blinks an
// acknowledge pattern on every change. Optional IDLE dimming via LED_IND_DIM_EN.
module mode_led_driver #(
    parameter int BLINK_TICKS = 2_500_000,
    parameter int NUM_BLINKS  = 3,
    parameter int PWM_W       = 8,
    parameter int DIM_DUTY    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] setting,
    input  logic       chg,
    output logic [1:0] led,
    output logic       busy
);

    localparam int TIMER_W  = $clog2(BLINK_TICKS);
    localparam int BLINKS_W = $clog2(NUM_BLINKS + 1);
    localparam logic [TIMER_W-1:0]  TIMER_RELOAD  = TIMER_W'(BLINK_TICKS - 1);
    localparam logic [BLINKS_W-1:0] BLINKS_RELOAD = BLINKS_W'(NUM_BLINKS);
    localparam logic [1:0]          POWER_ON_MODE = 2'b10;

    if (BLINK_TICKS < 2) begin : g_bad_blink_ticks
        $error("BLINK_TICKS must be >= 2");
    end
    if (NUM_BLINKS < 1) begin : g_bad_num_blinks
        $error("NUM_BLINKS must be >= 1");
    end
    if ((PWM_W < 1) || (DIM_DUTY < 0) || (DIM_DUTY > (2 ** PWM_W))) begin : g_bad_dim_cfg
        $error("PWM_W/DIM_DUTY out of range");
    end

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OFF  = 2'b01,
        ON   = 2'b10
    } state_t;

    state_t                state_r;
    state_t                next_state_s;
    logic [TIMER_W-1:0]    timer_r;
    logic [TIMER_W-1:0]    timer_next_s;
    logic [BLINKS_W-1:0]   blinks_r;
    logic [BLINKS_W-1:0]   blinks_next_s;
    logic [1:0]            shown_r;
    logic [1:0]            shown_next_s;
    logic [1:0]            idle_led_s;
    logic [1:0]            led_next_s;
    logic                  busy_next_s;

`ifdef LED_IND_DIM_EN
    localparam logic [PWM_W:0] DUTY_LIMIT = (PWM_W + 1)'(DIM_DUTY);

    logic [PWM_W-1:0] pwm_r;
    logic [PWM_W-1:0] pwm_next_s;

    // Free-running dimming counter; led is registered alongside it, so the
    // compare uses the value pwm takes on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_r <= {PWM_W{1'b0}};
        end else begin
            pwm_r <= pwm_next_s;
        end
    end

    // Dimmed steady-state drive.
    always_comb begin
        pwm_next_s = pwm_r + PWM_W'(1);
        idle_led_s = shown_next_s & {2{({1'b0, pwm_next_s} < DUTY_LIMIT)}};
    end
`else
    // Full-drive steady-state level.
    always_comb begin
        idle_led_s = shown_next_s;
    end
`endif

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            timer_r  <= {TIMER_W{1'b0}};
            blinks_r <= {BLINKS_W{1'b0}};
            shown_r  <= POWER_ON_MODE;
            led      <= 2'b00;
            busy     <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            timer_r  <= timer_next_s;
            blinks_r <= blinks_next_s;
            shown_r  <= shown_next_s;
            led      <= led_next_s;
            busy     <= busy_next_s;
        end
    end

    // Next-state and counter update; a change strobe overrides any expiry.
    always_comb begin
        next_state_s  = state_r;
        timer_next_s  = timer_r;
        blinks_next_s = blinks_r;
        shown_next_s  = shown_r;
        if (chg) begin
            shown_next_s  = setting;
            blinks_next_s = BLINKS_RELOAD;
            timer_next_s  = TIMER_RELOAD;
            next_state_s  = OFF;
        end else begin
            case (state_r)
                IDLE: begin
                    next_state_s = IDLE;
                end
                OFF: begin
                    if (timer_r == {TIMER_W{1'b0}}) begin
                        timer_next_s = TIMER_RELOAD;
                        next_state_s = ON;
                    end else begin
                        timer_next_s = timer_r - TIMER_W'(1);
                    end
                end
                ON: begin
                    if (timer_r == {TIMER_W{1'b0}}) begin
                        blinks_next_s = blinks_r - BLINKS_W'(1);
                        if (blinks_r == BLINKS_W'(1)) begin
                            next_state_s = IDLE;
                        end else begin
                            timer_next_s = TIMER_RELOAD;
                            next_state_s = OFF;
                        end
                    end else begin
                        timer_next_s = timer_r - TIMER_W'(1);
                    end
                end
                default: begin
                    next_state_s  = IDLE;
                    timer_next_s  = {TIMER_W{1'b0}};
                    blinks_next_s = {BLINKS_W{1'b0}};
                end
            endcase
        end
    end

    // Output decode from the state being entered.
    always_comb begin
        led_next_s  = 2'b00;
        busy_next_s = 1'b0;
        case (next_state_s)
            IDLE: begin
                led_next_s  = idle_led_s;
                busy_next_s = 1'b0;
            end
            OFF: begin
                led_next_s  = 2'b00;
                busy_next_s = 1'b1;
            end
            ON: begin
                led_next_s  = shown_next_s;
                busy_next_s = 1'b1;
            end
            default: begin
                led_next_s  = 2'b00;
                busy_next_s = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mode_led_driver.sv
// Bench for mode_led_driver with BLINK_TICKS=4, NUM_BLINKS=2.
// Vector table plus hand-written reset/dimming sequences, checked through a queue.
module tb_mode_led_driver;

    logic       clk;
    logic       rst;
    logic [1:0] setting;
    logic       chg;
    logic [1:0] led;
    logic       busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        logic [1:0] setting;
        logic       chg;
        logic [1:0] exp_led;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    mode_led_driver #(
        .BLINK_TICKS(4),
        .NUM_BLINKS (2),
        .PWM_W      (8),
        .DIM_DUTY   (64)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .setting(setting),
        .chg    (chg),
        .led    (led),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input string name, input int n, input logic [1:0] s,
                       input logic c, input logic [1:0] l, input logic b);
        for (int i = 0; i < n; i++) begin
            vec_t v;
            v.name = name; v.setting = s; v.chg = c; v.exp_led = l; v.exp_busy = b;
            vecs.push_back(v);
        end
    endtask

    task automatic check_now(input string name, input logic [1:0] l, input logic b);
        checks++;
        if (led !== l || busy !== b) begin
            errors++;
            $display("FAIL %s: got led=%b busy=%b, want led=%b busy=%b", name, led, busy, l, b);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v);
        vec_t e;
        setting = v.setting;
        chg     = v.chg;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        chg = 1'b0;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", v.name);
        end else begin
            e = exp_q.pop_front();
            check_now(e.name, e.exp_led, e.exp_busy);
        end
    endtask

    task automatic step(input string name, input logic [1:0] s, input logic c,
                        input logic [1:0] l, input logic b);
        vec_t v;
        v.name = name; v.setting = s; v.chg = c; v.exp_led = l; v.exp_busy = b;
        apply(v);
    endtask

    initial begin
        rst = 1'b1; setting = 2'b00; chg = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_now("reset_hold", 2'b00, 1'b0);
        rst = 1'b0;

`ifndef LED_IND_DIM_EN
        add("first_edge", 3, 2'b00, 1'b0, 2'b10, 1'b0);
        for (int i = 0; i < 4; i++)
            add("toggle_no_chg", 1, (i % 2 == 0) ? 2'b01 : 2'b11, 1'b0, 2'b10, 1'b0);
        add("blink11_chg",  1, 2'b11, 1'b1, 2'b00, 1'b1);
        add("blink11_off1", 3, 2'b11, 1'b0, 2'b00, 1'b1);
        add("blink11_on1",  4, 2'b11, 1'b0, 2'b11, 1'b1);
        add("blink11_off2", 4, 2'b11, 1'b0, 2'b00, 1'b1);
        add("blink11_on2",  4, 2'b11, 1'b0, 2'b11, 1'b1);
        add("blink11_idle", 2, 2'b11, 1'b0, 2'b11, 1'b0);
        add("retrig_chg01", 1, 2'b01, 1'b1, 2'b00, 1'b1);
        add("retrig_off",   3, 2'b01, 1'b0, 2'b00, 1'b1);
        add("retrig_on",    2, 2'b01, 1'b0, 2'b01, 1'b1);
        add("retrig_chg00", 1, 2'b00, 1'b1, 2'b00, 1'b1);
        add("retrig_seq00", 15, 2'b00, 1'b0, 2'b00, 1'b1);
        add("retrig_idle",  2, 2'b10, 1'b0, 2'b00, 1'b0);
        add("expiry_chg01", 1, 2'b01, 1'b1, 2'b00, 1'b1);
        add("expiry_off",   3, 2'b01, 1'b0, 2'b00, 1'b1);
        add("expiry_chg10", 1, 2'b10, 1'b1, 2'b00, 1'b1);
        add("expiry_off1",  3, 2'b10, 1'b0, 2'b00, 1'b1);
        add("expiry_on1",   4, 2'b10, 1'b0, 2'b10, 1'b1);
        add("expiry_off2",  4, 2'b10, 1'b0, 2'b00, 1'b1);
        add("expiry_on2",   4, 2'b10, 1'b0, 2'b10, 1'b1);
        add("expiry_idle",  2, 2'b00, 1'b0, 2'b10, 1'b0);

        foreach (vecs[i]) apply(vecs[i]);

        // Reset in the middle of an ON phase must drop everything at once.
        step("rst_mid_chg", 2'b11, 1'b1, 2'b00, 1'b1);
        for (int i = 0; i < 3; i++) step("rst_mid_off", 2'b11, 1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 2; i++) step("rst_mid_on", 2'b11, 1'b0, 2'b11, 1'b1);
        rst = 1'b1;
        #1;
        check_now("rst_async", 2'b00, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("rst_recover", 2'b11, 1'b0, 2'b10, 1'b0);
        step("rst_recover2", 2'b11, 1'b0, 2'b10, 1'b0);
`else
        begin
            int on_cnt;
            int off_cnt;
            on_cnt = 0;
            off_cnt = 0;
            for (int i = 0; i < 256; i++) begin
                @(posedge clk);
                #1;
                if (led == 2'b10) on_cnt++;
                else if (led == 2'b00) off_cnt++;
            end
            checks++;
            if (on_cnt != 64) begin
                errors++;
                $display("FAIL dim_on_cycles: got %0d, want 64", on_cnt);
            end
            checks++;
            if (off_cnt != 192) begin
                errors++;
                $display("FAIL dim_off_cycles: got %0d, want 192", off_cnt);
            end
            step("dim_blink_chg", 2'b11, 1'b1, 2'b00, 1'b1);
            for (int i = 0; i < 3; i++) step("dim_blink_off", 2'b11, 1'b0, 2'b00, 1'b1);
            for (int i = 0; i < 4; i++) step("dim_blink_full_on", 2'b11, 1'b0, 2'b11, 1'b1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
